// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch sequencer.
package fetch_pkg;

    localparam int INST_W = 18;
    localparam int ADDR_W = 12;
    localparam logic [ADDR_W-1:0] RESET_PC = 12'h000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2,
        EXEC   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_ret_stack.sv
// Return-address LIFO with full/empty flags; push/pop take effect on the clock edge.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);
    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_top_idx;
    logic [CW-1:0] w_cnt_dec;

    assign w_cnt_dec = r_cnt - CW'(1);
    assign w_wr_idx  = IW'(r_cnt);
    assign w_top_idx = IW'(w_cnt_dec);
    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_top     = r_mem[w_top_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_push && !o_full) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_cnt <= w_cnt_dec;
        end
    end

    // Entry storage carries no reset; the count alone defines which entries are live.
    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch/decode/execute sequencer owning the PC and instruction register.
// Optional return stack enabled by defining CALL_STACK_EN.
module inst_fetch_ctrl #(
    parameter int                   INST_W      = fetch_pkg::INST_W,
    parameter int                   ADDR_W      = fetch_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]    RESET_PC    = fetch_pkg::RESET_PC,
    parameter int                   STACK_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [INST_W-1:0] mem_data_i,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              exec_o,
    input  logic              exec_done_i,
    input  logic              pc_load_i,
    input  logic [ADDR_W-1:0] pc_target_i,
    input  logic              call_i,
    input  logic              ret_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              stack_err_o
);
    import fetch_pkg::*;

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [INST_W-1:0] r_inst;
    logic              w_done;

    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_done   = (r_state == EXEC) && exec_done_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (en_i) w_state_nxt = FETCH;
            FETCH:   if (mem_ack_i) w_state_nxt = DECODE;
            DECODE:  w_state_nxt = EXEC;
            EXEC:    if (exec_done_i) w_state_nxt = en_i ? FETCH : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef CALL_STACK_EN
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_err_set;
    logic [ADDR_W-1:0] w_top;
    logic              r_stack_err;

    // Conflicting or impossible stack requests flag an error and fall through to pc+1,
    // except an overflowing call, which still jumps.
    always_comb begin
        w_pc_nxt  = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        if (w_done) begin
            if (call_i && ret_i) begin
                w_err_set = 1'b1;
                w_pc_nxt  = w_pc_inc;
            end else if (ret_i) begin
                if (w_empty) begin
                    w_err_set = 1'b1;
                    w_pc_nxt  = w_pc_inc;
                end else begin
                    w_pop    = 1'b1;
                    w_pc_nxt = w_top;
                end
            end else if (call_i) begin
                w_pc_nxt  = pc_target_i;
                w_err_set = w_full;
                w_push    = !w_full;
            end else if (pc_load_i) begin
                w_pc_nxt = pc_target_i;
            end else begin
                w_pc_nxt = w_pc_inc;
            end
        end
    end

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stack_err <= 1'b0;
        end else if (w_err_set) begin
            r_stack_err <= 1'b1;
        end
    end

    assign stack_err_o = r_stack_err;
`else
    logic w_unused_call_ret;

    always_comb begin
        w_pc_nxt = r_pc;
        if (w_done) begin
            w_pc_nxt = pc_load_i ? pc_target_i : w_pc_inc;
        end
    end

    assign w_unused_call_ret = &{1'b0, call_i, ret_i, (STACK_DEPTH > 0)};
    assign stack_err_o       = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if ((r_state == FETCH) && mem_ack_i) begin
                r_inst <= mem_data_i;
            end
        end
    end

    // Strobes decode straight from state so an async reset silences them at once.
    assign mem_req_o    = (r_state == FETCH);
    assign inst_valid_o = (r_state == DECODE);
    assign exec_o       = (r_state == EXEC);
    assign mem_addr_o   = r_pc;
    assign pc_o         = r_pc;
    assign inst_o       = r_inst;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed scoreboard bench for inst_fetch_ctrl; stack scenario runs when CALL_STACK_EN is defined.
module tb_inst_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic        mem_req_o;
    logic [11:0] mem_addr_o;
    logic        mem_ack_i;
    logic [17:0] mem_data_i;
    logic [17:0] inst_o;
    logic        inst_valid_o;
    logic        exec_o;
    logic        exec_done_i;
    logic        pc_load_i;
    logic [11:0] pc_target_i;
    logic        call_i;
    logic        ret_i;
    logic [11:0] pc_o;
    logic        stack_err_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [17:0] q_inst [$];
    logic [11:0] stk [$];
    logic [11:0] exp_pc;
    logic [17:0] last_inst;
    logic        exp_err;

    always #5 clk_i = ~clk_i;

    inst_fetch_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .exec_o       (exec_o),
        .exec_done_i  (exec_done_i),
        .pc_load_i    (pc_load_i),
        .pc_target_i  (pc_target_i),
        .call_i       (call_i),
        .ret_i        (ret_i),
        .pc_o         (pc_o),
        .stack_err_o  (stack_err_o)
    );

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},    32'(pc_o),         32'h000);
        check({tag, "_addr"},  32'(mem_addr_o),   32'h000);
        check({tag, "_inst"},  32'(inst_o),       32'h0);
        check({tag, "_req"},   32'(mem_req_o),    32'h0);
        check({tag, "_valid"}, 32'(inst_valid_o), 32'h0);
        check({tag, "_exec"},  32'(exec_o),       32'h0);
        check({tag, "_err"},   32'(stack_err_o),  32'h0);
    endtask

    // Independent PC / return-stack model applied at each completed instruction.
    task automatic model_done(input logic load, input logic [11:0] tgt,
                              input logic call, input logic ret);
`ifdef CALL_STACK_EN
        if (call && ret) begin
            exp_err = 1'b1;
            exp_pc  = exp_pc + 12'd1;
        end else if (ret) begin
            if (stk.size() == 0) begin
                exp_err = 1'b1;
                exp_pc  = exp_pc + 12'd1;
            end else begin
                exp_pc = stk.pop_back();
            end
        end else if (call) begin
            if (stk.size() == 4) exp_err = 1'b1;
            else stk.push_back(exp_pc + 12'd1);
            exp_pc = tgt;
        end else if (load) begin
            exp_pc = tgt;
        end else begin
            exp_pc = exp_pc + 12'd1;
        end
`else
        exp_pc = load ? tgt : exp_pc + 12'd1;
`endif
    endtask

    // Entered with the DUT in FETCH; leaves it just after the completing edge.
    task automatic do_instr(input logic [17:0] data, input int ack_wait, input int done_wait,
                            input logic load, input logic [11:0] tgt,
                            input logic call, input logic ret, input logic en_drop);
        logic [17:0] exp_inst;
        check("fetch_req",  32'(mem_req_o),  32'h1);
        check("fetch_addr", 32'(mem_addr_o), 32'(exp_pc));
        q_inst.push_back(data);
        if (en_drop) en_i = 1'b0;
        for (int i = 0; i < ack_wait; i++) begin
            mem_ack_i  = 1'b0;
            mem_data_i = 18'h3FFFF;
            tick();
            check("wait_req",   32'(mem_req_o),    32'h1);
            check("wait_addr",  32'(mem_addr_o),   32'(exp_pc));
            check("wait_valid", 32'(inst_valid_o), 32'h0);
            check("wait_inst",  32'(inst_o),       32'(last_inst));
        end
        mem_ack_i  = 1'b1;
        mem_data_i = data;
        tick();
        exp_inst = (q_inst.size() > 0) ? q_inst.pop_front() : 18'bx;
        last_inst = exp_inst;
        check("dec_valid", 32'(inst_valid_o), 32'h1);
        check("dec_req",   32'(mem_req_o),    32'h0);
        check("dec_inst",  32'(inst_o),       32'(exp_inst));
        mem_data_i = ~data;
        tick();
        mem_ack_i = 1'b0;
        check("exec_strobe", 32'(exec_o),       32'h1);
        check("exec_valid",  32'(inst_valid_o), 32'h0);
        check("exec_inst",   32'(inst_o),       32'(last_inst));
        for (int i = 0; i < done_wait; i++) begin
            tick();
            check("exec_hold", 32'(exec_o), 32'h1);
            check("exec_pc",   32'(pc_o),   32'(exp_pc));
        end
        exec_done_i = 1'b1;
        pc_load_i   = load;
        pc_target_i = tgt;
        call_i      = call;
        ret_i       = ret;
        tick();
        exec_done_i = 1'b0;
        pc_load_i   = 1'b0;
        call_i      = 1'b0;
        ret_i       = 1'b0;
        model_done(load, tgt, call, ret);
        check("done_pc",   32'(pc_o),        32'(exp_pc));
        check("done_req",  32'(mem_req_o),   32'(en_i));
        check("done_exec", 32'(exec_o),      32'h0);
        check("done_err",  32'(stack_err_o), 32'(exp_err));
    endtask

    initial begin
        rst_ni      = 1'b0;
        en_i        = 1'b0;
        mem_ack_i   = 1'b0;
        mem_data_i  = '0;
        exec_done_i = 1'b0;
        pc_load_i   = 1'b0;
        pc_target_i = '0;
        call_i      = 1'b0;
        ret_i       = 1'b0;
        exp_pc      = 12'h000;
        last_inst   = '0;
        exp_err     = 1'b0;

        tick();
        tick();
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        tick();
        check("idle_req", 32'(mem_req_o), 32'h0);
        en_i = 1'b1;
        tick();

        // Zero-wait fetch, then delayed ack with a slow datapath.
        do_instr(18'h2A5C3, 0, 0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        do_instr(18'h1B0F4, 3, 2, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);

        // Jump, then wrap from FFF to 000.
        do_instr(18'h00111, 0, 0, 1'b1, 12'h7F0, 1'b0, 1'b0, 1'b0);
        do_instr(18'h00222, 1, 0, 1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0);
        do_instr(18'h00333, 0, 0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        check("wrap_addr", 32'(mem_addr_o), 32'h000);

        // Enable dropped while waiting for ack.
        do_instr(18'h12345, 2, 1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
        tick();
        check("idle_req2",  32'(mem_req_o), 32'h0);
        check("idle_exec2", 32'(exec_o),    32'h0);
        check("idle_pc2",   32'(pc_o),      32'(exp_pc));
        en_i = 1'b1;
        tick();

        // Asynchronous reset in the middle of EXEC.
        do_instr(18'h0ABCD, 0, 0, 1'b1, 12'h345, 1'b0, 1'b0, 1'b0);
        q_inst.push_back(18'h3C3C3);
        mem_ack_i  = 1'b1;
        mem_data_i = 18'h3C3C3;
        tick();
        mem_ack_i = 1'b0;
        check("rst_dec_inst", 32'(inst_o), 32'(q_inst.pop_front()));
        tick();
        check("rst_exec_pre", 32'(exec_o), 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_pc    = 12'h000;
        last_inst = '0;
        exp_err   = 1'b0;
        stk.delete();
        #3;
        rst_ni = 1'b1;
        tick();

`ifdef CALL_STACK_EN
        // Five nested calls overflow a 4-deep stack; five returns underflow it.
        do_instr(18'h00001, 0, 0, 1'b1, 12'h010, 1'b0, 1'b0, 1'b0);
        do_instr(18'h00002, 0, 0, 1'b0, 12'h020, 1'b1, 1'b0, 1'b0);
        do_instr(18'h00003, 0, 0, 1'b0, 12'h030, 1'b1, 1'b0, 1'b0);
        do_instr(18'h00004, 0, 0, 1'b0, 12'h040, 1'b1, 1'b0, 1'b0);
        do_instr(18'h00005, 0, 0, 1'b0, 12'h050, 1'b1, 1'b0, 1'b0);
        check("call4_err", 32'(stack_err_o), 32'h0);
        do_instr(18'h00006, 1, 0, 1'b0, 12'h060, 1'b1, 1'b0, 1'b0);
        check("call5_pc",  32'(pc_o),        32'h060);
        check("call5_err", 32'(stack_err_o), 32'h1);
        do_instr(18'h00007, 0, 0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
        check("ret1_pc", 32'(pc_o), 32'h041);
        do_instr(18'h00008, 0, 0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
        check("ret2_pc", 32'(pc_o), 32'h031);
        do_instr(18'h00009, 0, 1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
        check("ret3_pc", 32'(pc_o), 32'h021);
        do_instr(18'h0000A, 0, 0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
        check("ret4_pc", 32'(pc_o), 32'h011);
        do_instr(18'h0000B, 0, 0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
        check("ret5_pc",  32'(pc_o),        32'h012);
        check("ret5_err", 32'(stack_err_o), 32'h1);
        do_instr(18'h0000C, 0, 0, 1'b0, 12'h200, 1'b1, 1'b1, 1'b0);
        check("callret_pc", 32'(pc_o), 32'h013);
`else
        // Call/return requests have no effect without the stack.
        do_instr(18'h00001, 0, 0, 1'b0, 12'h123, 1'b1, 1'b0, 1'b0);
        check("nocall_pc", 32'(pc_o), 32'h001);
        do_instr(18'h00002, 0, 0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
        check("noret_pc", 32'(pc_o), 32'h002);
        do_instr(18'h00003, 0, 0, 1'b1, 12'h456, 1'b1, 1'b1, 1'b0);
        check("load_with_callret", 32'(pc_o),        32'h456);
        check("noerr",             32'(stack_err_o), 32'h0);
`endif

        check("sb_drained", 32'(q_inst.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
